// File: rtl/fetch_ctrl.sv
// Program-counter sequencer for the MIPS instruction fetch stage.
// Drives the instruction-memory index and handles stall, redirect, exception and ERET flow.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC  = 32'h0000_4180,
    parameter int          IM_WORDS = 4096,
    parameter int          IDX_W    = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stall_i,
    input  logic              br_valid_i,
    input  logic [31:0]       br_target_i,
    input  logic              exc_req_i,
    input  logic              eret_req_i,
    input  logic [31:0]       epc_i,
    output logic [31:0]       pc_o,
    output logic [IDX_W-1:0]  im_index_o,
    output logic              fetch_valid_o,
    output logic              fetch_exc_o,
    output logic [4:0]        exc_code_o,
    output logic [31:0]       fetch_cnt_o
);

    typedef enum logic [1:0] {BOOT, RUN, PEND} state_t;

    // One past the last byte of instruction memory; 33 bits so the sum cannot wrap.
    localparam logic [32:0] PC_LIMIT = {1'b0, RESET_PC} + 33'(4 * IM_WORDS);

    state_t      state, state_nxt;
    logic [31:0] pc_nxt;
    logic        pend_valid, pend_valid_nxt;
    logic [31:0] pend_pc, pend_pc_nxt;
    logic        cnt_inc;

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc_o;
        pend_valid_nxt = pend_valid;
        pend_pc_nxt    = pend_pc;
        cnt_inc        = 1'b0;

        case (state)
            BOOT: begin
                state_nxt = RUN;
            end
            default: begin
                if (exc_req_i) begin
                    pc_nxt         = EXC_VEC;
                    pend_valid_nxt = 1'b0;
                    pend_pc_nxt    = 32'd0;
                    state_nxt      = RUN;
                    cnt_inc        = 1'b1;
                end else if (eret_req_i) begin
                    pc_nxt         = epc_i;
                    pend_valid_nxt = 1'b0;
                    pend_pc_nxt    = 32'd0;
                    state_nxt      = RUN;
                    cnt_inc        = 1'b1;
                end else if (stall_i) begin
                    // First redirect seen during a stall wins; later ones are dropped.
                    if (br_valid_i && !pend_valid) begin
                        pend_pc_nxt    = br_target_i;
                        pend_valid_nxt = 1'b1;
                        state_nxt      = PEND;
                    end
                end else if (state == PEND) begin
                    pc_nxt         = pend_pc;
                    pend_valid_nxt = 1'b0;
                    pend_pc_nxt    = 32'd0;
                    state_nxt      = RUN;
                    cnt_inc        = 1'b1;
                end else if (br_valid_i) begin
                    pc_nxt  = br_target_i;
                    cnt_inc = 1'b1;
                end else begin
                    pc_nxt  = pc_o + 32'd4;
                    cnt_inc = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= BOOT;
            pc_o        <= RESET_PC;
            pend_valid  <= 1'b0;
            pend_pc     <= 32'd0;
            fetch_cnt_o <= 32'd0;
        end else begin
            state      <= state_nxt;
            pc_o       <= pc_nxt;
            pend_valid <= pend_valid_nxt;
            pend_pc    <= pend_pc_nxt;
            if (cnt_inc) begin
                fetch_cnt_o <= fetch_cnt_o + 32'd1;
            end
        end
    end

    // RESET_PC is word aligned, so the word index needs no borrow from bits [1:0].
    assign im_index_o    = pc_o[IDX_W+1:2] - RESET_PC[IDX_W+1:2];
    assign fetch_valid_o = (state != BOOT);
    assign fetch_exc_o   = fetch_valid_o &&
                           ((pc_o[1:0] != 2'b00) || (pc_o < RESET_PC) ||
                            ({1'b0, pc_o} >= PC_LIMIT));
    assign exc_code_o    = fetch_exc_o ? 5'd4 : 5'd0;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: each driven cycle queues its expected outputs,
// which are popped and compared one time unit after the following rising edge.
module tb_fetch_ctrl;

    logic        clk;
    logic        reset_n;
    logic        stall_i;
    logic        br_valid_i;
    logic [31:0] br_target_i;
    logic        exc_req_i;
    logic        eret_req_i;
    logic [31:0] epc_i;
    logic [31:0] pc_o;
    logic [11:0] im_index_o;
    logic        fetch_valid_o;
    logic        fetch_exc_o;
    logic [4:0]  exc_code_o;
    logic [31:0] fetch_cnt_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        valid;
        logic        exc;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];

    fetch_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .stall_i      (stall_i),
        .br_valid_i   (br_valid_i),
        .br_target_i  (br_target_i),
        .exc_req_i    (exc_req_i),
        .eret_req_i   (eret_req_i),
        .epc_i        (epc_i),
        .pc_o         (pc_o),
        .im_index_o   (im_index_o),
        .fetch_valid_o(fetch_valid_o),
        .fetch_exc_o  (fetch_exc_o),
        .exc_code_o   (exc_code_o),
        .fetch_cnt_o  (fetch_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic compare_now(input exp_t e);
        logic [31:0] off;
        check_val({e.tag, ".pc"},    pc_o,                 e.pc);
        check_val({e.tag, ".valid"}, 32'(fetch_valid_o),   32'(e.valid));
        check_val({e.tag, ".exc"},   32'(fetch_exc_o),     32'(e.exc));
        check_val({e.tag, ".code"},  32'(exc_code_o),      e.exc ? 32'd4 : 32'd0);
        check_val({e.tag, ".cnt"},   fetch_cnt_o,          e.cnt);
        if (!e.exc) begin
            off = e.pc - 32'h0000_3000;
            check_val({e.tag, ".idx"}, 32'(im_index_o), 32'(off[13:2]));
        end
    endtask

    task automatic step(input string tag,
                        input logic stall, input logic br, input logic [31:0] tgt,
                        input logic exc, input logic eret, input logic [31:0] epc,
                        input logic [31:0] exp_pc, input logic exp_valid,
                        input logic exp_exc, input logic [31:0] exp_cnt);
        exp_t e;
        stall_i     = stall;
        br_valid_i  = br;
        br_target_i = tgt;
        exc_req_i   = exc;
        eret_req_i  = eret;
        epc_i       = epc;
        e.tag   = tag;
        e.pc    = exp_pc;
        e.valid = exp_valid;
        e.exc   = exp_exc;
        e.cnt   = exp_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare_now(sb.pop_front());
    endtask

    task automatic idle_inputs();
        stall_i     = 1'b0;
        br_valid_i  = 1'b0;
        br_target_i = 32'd0;
        exc_req_i   = 1'b0;
        eret_req_i  = 1'b0;
        epc_i       = 32'd0;
    endtask

    initial begin
        exp_t e;
        reset_n = 1'b0;
        idle_inputs();
        #12;
        e = '{"rst", 32'h3000, 1'b0, 1'b0, 32'd0};
        compare_now(e);

        @(negedge clk);
        reset_n = 1'b1;
        #1;
        e = '{"boot", 32'h3000, 1'b0, 1'b0, 32'd0};
        compare_now(e);

        // Sequential fetch from reset
        step("seq0", 0, 0, 0,        0, 0, 0, 32'h3000, 1, 0, 32'd0);
        step("seq1", 0, 0, 0,        0, 0, 0, 32'h3004, 1, 0, 32'd1);
        step("seq2", 0, 0, 0,        0, 0, 0, 32'h3008, 1, 0, 32'd2);
        step("br1",  0, 1, 32'h3100, 0, 0, 0, 32'h3100, 1, 0, 32'd3);
        step("br2",  0, 1, 32'h3010, 0, 0, 0, 32'h3010, 1, 0, 32'd4);

        // Stall with competing branches: first target wins
        step("stl0", 1, 1, 32'h3200, 0, 0, 0, 32'h3010, 1, 0, 32'd4);
        step("stl1", 1, 1, 32'h3300, 0, 0, 0, 32'h3010, 1, 0, 32'd4);
        step("stl2", 1, 0, 0,        0, 0, 0, 32'h3010, 1, 0, 32'd4);
        step("prel", 0, 0, 0,        0, 0, 0, 32'h3200, 1, 0, 32'd5);

        // Exception overrides stall and discards the pending redirect
        step("pnd",  1, 1, 32'h3200, 0, 0, 0, 32'h3200, 1, 0, 32'd5);
        step("exc",  1, 0, 0,        1, 0, 0, 32'h4180, 1, 0, 32'd6);
        step("aexc", 0, 0, 0,        0, 0, 0, 32'h4184, 1, 0, 32'd7);
        step("pnd2", 1, 1, 32'h3400, 0, 0, 0, 32'h4184, 1, 0, 32'd7);
        step("prl2", 0, 0, 0,        0, 0, 0, 32'h3400, 1, 0, 32'd8);
        step("eret", 1, 0, 0,        0, 1, 32'h3014, 32'h3014, 1, 0, 32'd9);

        // Fetch address errors and range boundaries
        step("mis",  0, 1, 32'h3002, 0, 0, 0, 32'h3002, 1, 1, 32'd10);
        step("hi",   0, 1, 32'h7000, 0, 0, 0, 32'h7000, 1, 1, 32'd11);
        step("top",  0, 1, 32'h6FFC, 0, 0, 0, 32'h6FFC, 1, 0, 32'd12);
        step("wrap", 0, 0, 0,        0, 0, 0, 32'h7000, 1, 1, 32'd13);
        step("lo",   0, 1, 32'h2FFC, 0, 0, 0, 32'h2FFC, 1, 1, 32'd14);

        // Async reset while a redirect is pending
        step("rpb",  0, 1, 32'h3040, 0, 0, 0, 32'h3040, 1, 0, 32'd15);
        step("rpnd", 1, 1, 32'h3500, 0, 0, 0, 32'h3040, 1, 0, 32'd15);
        #2;
        reset_n = 1'b0;
        #1;
        e = '{"arst", 32'h3000, 1'b0, 1'b0, 32'd0};
        compare_now(e);
        @(negedge clk);
        idle_inputs();
        reset_n = 1'b1;
        #1;
        e = '{"boot2", 32'h3000, 1'b0, 1'b0, 32'd0};
        compare_now(e);
        step("bign", 1, 1, 32'h3500, 1, 0, 0, 32'h3000, 1, 0, 32'd0);
        step("post", 0, 0, 0,        0, 0, 0, 32'h3004, 1, 0, 32'd1);
        step("pst2", 0, 0, 0,        0, 0, 0, 32'h3008, 1, 0, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
